// File: rtl/axis_i2c_pkg.sv
// axis_i2c_pkg: shared types, widths and quarter-phase waveforms for the AXIS-to-I2C byte writer
package axis_i2c_pkg;
  localparam int AXIS_DATA_WIDTH = 8;
  localparam int MAX_DIVIDER = 65536;
  localparam int CNT_WIDTH = $clog2(MAX_DIVIDER);
  typedef enum logic [2:0] {IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP} i2c_state_t;
  localparam logic [3:0] START_SDA = 4'b0001;
  localparam logic [3:0] START_SCL = 4'b0111;
  localparam logic [3:0] BIT_SCL = 4'b0110;
  localparam logic [3:0] STOP_SDA = 4'b1100;
  localparam logic [3:0] STOP_SCL = 4'b1110;
endpackage

// File: rtl/i2c_quarter_tick.sv
// i2c_quarter_tick: quarter-bit divider giving a one-cycle tick and a 2-bit phase index
module i2c_quarter_tick
  import axis_i2c_pkg::*;
#(
  parameter int DIVIDER = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       tick,
  output logic [1:0] q
);
  logic [CNT_WIDTH-1:0] cnt;
  assign tick = en && cnt == CNT_WIDTH'(DIVIDER - 1);
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
      q <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      q <= tick ? q + 2'd1 : q;
    end
  end
endmodule

// File: rtl/axis_i2c_byte_writer.sv
// axis_i2c_byte_writer: AXIS bytes to I2C write transactions on push-pull sda/scl (AXIS_I2C_BURST_EN chains bytes into one transaction)
module axis_i2c_byte_writer
  import axis_i2c_pkg::*;
#(
  parameter int         DATA_WIDTH = 8,
  parameter int         CLK_FREQ = 50_000_000,
  parameter int         I2C_FREQ = 100_000,
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  sda,
  output logic                  scl,
  output logic                  busy
);
  localparam int DIVIDER = CLK_FREQ / (4 * I2C_FREQ);
  if (DIVIDER < 1 || DIVIDER > MAX_DIVIDER || DATA_WIDTH != AXIS_DATA_WIDTH) begin : g_bad_cfg
    $error("axis_i2c_byte_writer: DATA_WIDTH must be 8 and DIVIDER must be 1..%0d", MAX_DIVIDER);
  end
  i2c_state_t state, state_n;
  logic tick, bit_end, take_more, hs, sda_n, scl_n;
  logic [1:0] q;
  logic [2:0] bit_cnt;
  logic [7:0] shreg, data_reg;
  i2c_quarter_tick #(.DIVIDER(DIVIDER)) u_tick (
    .clk (clk),
    .rst (arst),
    .en  (state != IDLE),
    .tick(tick),
    .q   (q)
  );
  assign bit_end = tick && q == 2'd3;
`ifdef AXIS_I2C_BURST_EN
  assign take_more = state == DATA_ACK && bit_end;
`else
  assign take_more = 1'b0;
`endif
  assign s_axis_tready = (state == IDLE || take_more) && !arst;
  assign hs = s_axis_tvalid && s_axis_tready;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    sda_n = 1'b1;
    scl_n = 1'b1;
    case (state)
      IDLE:     state_n = hs ? START : IDLE;
      START:    begin state_n = bit_end ? ADDR : START; sda_n = START_SDA[q]; scl_n = START_SCL[q]; end
      ADDR:     begin state_n = bit_end && bit_cnt == 3'd0 ? ADDR_ACK : ADDR; sda_n = shreg[7]; scl_n = BIT_SCL[q]; end
      ADDR_ACK: begin state_n = bit_end ? DATA : ADDR_ACK; scl_n = BIT_SCL[q]; end
      DATA:     begin state_n = bit_end && bit_cnt == 3'd0 ? DATA_ACK : DATA; sda_n = shreg[7]; scl_n = BIT_SCL[q]; end
      DATA_ACK: begin state_n = bit_end ? (hs ? DATA : STOP) : DATA_ACK; scl_n = BIT_SCL[q]; end
      STOP:     begin state_n = bit_end ? IDLE : STOP; sda_n = STOP_SDA[q]; scl_n = STOP_SCL[q]; end
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (arst) begin
      state <= IDLE;
      sda <= 1'b1;
      scl <= 1'b1;
    end else begin
      state <= state_n;
      sda <= sda_n;
      scl <= scl_n;
    end
  end
  always_ff @(posedge clk) begin
    if (arst) begin
      bit_cnt <= '0;
      shreg <= '0;
      data_reg <= '0;
    end else begin
      if (hs) data_reg <= s_axis_tdata;
      if (bit_end) begin
        shreg <= state == START ? {SLAVE_ADDR, 1'b0} : state == ADDR_ACK ? data_reg : state == DATA_ACK ? s_axis_tdata : {shreg[6:0], 1'b0};
        bit_cnt <= (state == ADDR || state == DATA) ? bit_cnt - 3'd1 : 3'd7;
      end
    end
  end
endmodule

// File: tb/tb_axis_i2c_byte_writer.sv
// tb_axis_i2c_byte_writer: directed checks of reset, framing, timing and bus protocol of axis_i2c_byte_writer
module tb_axis_i2c_byte_writer;
  localparam int D = 10;
`ifdef AXIS_I2C_BURST_EN
  localparam int BUSY_RDY = 1;
`else
  localparam int BUSY_RDY = 0;
`endif
  logic clk = 1'b0, arst = 1'b1, s_axis_tvalid = 1'b0;
  logic [7:0] s_axis_tdata = 8'h00;
  logic s_axis_tready, sda, scl, busy;
  int total = 0, bad = 0, viol = 0;
  int fr_nb[$];
  logic [63:0] fr_bits[$];
  logic psda = 1'b1, pscl = 1'b1, parst = 1'b1;
  bit in_frame = 1'b0;
  int nb = 0;
  logic [63:0] bits = '0;
  axis_i2c_byte_writer #(
    .DATA_WIDTH(8),
    .CLK_FREQ  (4_000_000),
    .I2C_FREQ  (100_000),
    .SLAVE_ADDR(7'h50)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .sda          (sda),
    .scl          (scl),
    .busy         (busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (arst || parst) begin
      in_frame = 1'b0;
      nb = 0;
    end else begin
      if (scl && pscl && psda && !sda) begin
        if (in_frame) viol++;
        in_frame = 1'b1;
        nb = 0;
        bits = '0;
      end else if (scl && pscl && !psda && sda) begin
        if (in_frame) begin
          fr_nb.push_back(nb);
          fr_bits.push_back(bits);
        end else viol++;
        in_frame = 1'b0;
      end else if (sda != psda && scl != pscl) viol++;
      if (in_frame && scl && !pscl) begin
        if (nb < 64) bits[nb] = sda;
        nb++;
      end
    end
    psda = sda;
    pscl = scl;
    parst = arst;
  end
  function automatic logic [7:0] byte_at(input logic [63:0] b, input int k);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = b[9*k+i];
    return r;
  endfunction
  task automatic check_frame(input string tag, input int n, input logic [23:0] data);
    int fnb;
    logic [63:0] fb;
    check({tag, "_frames"}, fr_nb.size(), 1);
    if (fr_nb.size() == 0) return;
    fnb = fr_nb.pop_front();
    fb = fr_bits.pop_front();
    check({tag, "_edges"}, fnb, 1 + 9 * (n + 1));
    check({tag, "_addr"}, byte_at(fb, 0), 8'hA0);
    for (int j = 0; j <= n; j++) check($sformatf("%s_ack%0d", tag, j), fb[9*j+8], 1);
    for (int j = 0; j < n; j++) check($sformatf("%s_data%0d", tag, j), byte_at(fb, j + 1), data[8*j+:8]);
    check({tag, "_stop_low"}, fb[9*(n+1)], 0);
  endtask
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!s_axis_tready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, s_axis_tready, 1);
  endtask
  task automatic measure(output int cyc, output int fall, output int rdy);
    cyc = 0;
    fall = 0;
    rdy = 0;
    while (busy && cyc < 5000) begin
      cyc++;
      if (!sda && fall == 0) fall = cyc;
      if (s_axis_tready) rdy++;
      @(negedge clk);
    end
  endtask
  task automatic send_one(input string tag, input logic [7:0] b);
    int cyc, fall, rdy;
    wait_ready(tag);
    s_axis_tdata = b;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    measure(cyc, fall, rdy);
    check({tag, "_busy_cycles"}, cyc, 80 * D);
    check({tag, "_first_fall"}, fall, D + 2);
    check({tag, "_tready_busy"}, rdy, BUSY_RDY);
    check({tag, "_tready_after"}, s_axis_tready, 1);
    check_frame(tag, 1, {16'h0, b});
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int cyc, fall, rdy;
    logic [7:0] vec[4];
    vec = '{8'h5A, 8'h81, 8'h7E, 8'h01};
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 8'h55;
    arst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sda", sda, 1);
    check("rst_scl", scl, 1);
    check("rst_tready", s_axis_tready, 0);
    check("rst_busy", busy, 0);
    arst = 1'b0;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    check("idle_tready", s_axis_tready, 1);
    check("idle_busy", busy, 0);
    send_one("single", 8'hA5);
`ifndef AXIS_I2C_BURST_EN
    wait_ready("b2b");
    s_axis_tdata = 8'h00;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    s_axis_tdata = 8'hFF;
    measure(cyc, fall, rdy);
    check("b2b0_busy_cycles", cyc, 80 * D);
    check("b2b0_first_fall", fall, D + 2);
    check("b2b_gap_ready", s_axis_tready, 1);
    check_frame("b2b0", 1, 24'h0000_00);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    check("b2b1_accepted", busy, 1);
    measure(cyc, fall, rdy);
    check("b2b1_busy_cycles", cyc, 80 * D);
    check("b2b1_first_fall", fall, D + 2);
    check_frame("b2b1", 1, 24'h0000_FF);
`endif
    foreach (vec[i]) send_one($sformatf("proto%0d", i), vec[i]);
    check("proto_violations", viol, 0);
    wait_ready("midrst");
    s_axis_tdata = 8'hC3;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    repeat (578) @(negedge clk);
    check("midrst_inflight", busy, 1);
    arst = 1'b1;
    @(negedge clk);
    check("midrst_sda", sda, 1);
    check("midrst_scl", scl, 1);
    check("midrst_busy", busy, 0);
    arst = 1'b0;
    @(negedge clk);
    check("midrst_tready", s_axis_tready, 1);
    fr_nb.delete();
    fr_bits.delete();
    send_one("after_rst", 8'h3C);
`ifdef AXIS_I2C_BURST_EN
    begin
      logic [7:0] bv[3];
      int idx;
      bit hs;
      bv = '{8'h11, 8'h22, 8'h33};
      wait_ready("burst");
      s_axis_tdata = bv[0];
      s_axis_tvalid = 1'b1;
      @(negedge clk);
      s_axis_tdata = bv[1];
      idx = 1;
      cyc = 0;
      while (busy && cyc < 5000) begin
        cyc++;
        hs = s_axis_tready && s_axis_tvalid;
        @(negedge clk);
        if (hs) begin
          idx++;
          if (idx < 3) s_axis_tdata = bv[idx];
          else s_axis_tvalid = 1'b0;
        end
      end
      check("burst_busy_cycles", cyc, 38 * 4 * D);
      check("burst_accepted", idx, 3);
      check_frame("burst", 3, 24'h33_22_11);
    end
`endif
    check("final_violations", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
